// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave: the FSM encoding, datapath widths and
// the default idle level on miso.
package spi_pkg;
  localparam int BYTE_W = 8;
  localparam int CNT_W = 3;
  localparam logic MISO_IDLE_DEFAULT = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;
endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous input. The reset value is
// configurable so that edge detection downstream never sees a false edge.
module spi_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic sclk,
  input  logic nrst,
  input  logic d,
  output logic q
);
  logic [SYNC_STAGES-1:0] stage_reg;

  always_ff @(posedge sclk) begin
    if (!nrst) begin
      stage_reg <= {SYNC_STAGES{RST_VAL}};
    end else begin
      stage_reg <= {stage_reg[SYNC_STAGES-2:0], d};
    end
  end

  assign q = stage_reg[SYNC_STAGES-1];
endmodule

// File: rtl/spi_slave.sv
// Mode-0 SPI slave, MSB first, oversampled by sclk. All SPI pins are
// synchronized, and the serial protocol is recovered from detected sck edges.
module spi_slave
  import spi_pkg::*;
#(
  parameter logic MISO_IDLE   = MISO_IDLE_DEFAULT,
  parameter int   SYNC_STAGES = 2
) (
  input  logic                sclk,
  input  logic                nrst,
  input  logic                cs_n,
  input  logic                sck,
  input  logic                mosi,
  output logic                miso,
  output logic                miso_oe,
  input  logic [BYTE_W-1:0]   tx_byte,
  input  logic                tx_load,
  output logic                tx_req,
  output logic [BYTE_W-1:0]   rx_byte,
  output logic                rx_valid,
  output logic                busy
);
  logic cs_s, sck_s, mosi_s;
  logic cs_prev_reg, sck_prev_reg;
  logic cs_fall, cs_rise, sck_rise, sck_fall;

  state_t state_reg, state_next;
  logic [BYTE_W-1:0] tx_buf_reg, tx_shift_reg, rx_shift_reg;
  logic [CNT_W-1:0]  bit_cnt_reg;
  logic              byte_end_reg;

  logic              do_start, do_abort, do_rise, do_fall;
  logic [BYTE_W-1:0] load_val;

  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .sclk(sclk), .nrst(nrst), .d(cs_n), .q(cs_s)
  );
  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .sclk(sclk), .nrst(nrst), .d(sck), .q(sck_s)
  );
  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .sclk(sclk), .nrst(nrst), .d(mosi), .q(mosi_s)
  );

  assign cs_fall  = cs_prev_reg & ~cs_s;
  assign cs_rise  = ~cs_prev_reg & cs_s;
  assign sck_rise = ~sck_prev_reg & sck_s;
  assign sck_fall = sck_prev_reg & ~sck_s;

  always_ff @(posedge sclk) begin
    if (!nrst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // A cs_n rise masks any sck edge seen in the same cycle.
  always_comb begin
    state_next = state_reg;
    do_start   = 1'b0;
    do_abort   = 1'b0;
    do_rise    = 1'b0;
    do_fall    = 1'b0;
    load_val   = tx_load ? tx_byte : tx_buf_reg;
    case (state_reg)
      IDLE: begin
        if (cs_fall) begin
          state_next = SHIFT;
          do_start   = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_next = IDLE;
          do_abort   = 1'b1;
        end else begin
          do_rise = sck_rise;
          do_fall = sck_fall;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge sclk) begin
    if (!nrst) begin
      cs_prev_reg  <= 1'b1;
      sck_prev_reg <= 1'b0;
      miso         <= MISO_IDLE;
      miso_oe      <= 1'b0;
      busy         <= 1'b0;
      tx_req       <= 1'b0;
      rx_valid     <= 1'b0;
      rx_byte      <= '0;
      tx_buf_reg   <= '1;
      tx_shift_reg <= '1;
      rx_shift_reg <= '0;
      bit_cnt_reg  <= '0;
      byte_end_reg <= 1'b0;
    end else begin
      cs_prev_reg  <= cs_s;
      sck_prev_reg <= sck_s;
      tx_req       <= 1'b0;
      rx_valid     <= 1'b0;
      if (tx_load) begin
        tx_buf_reg <= tx_byte;
      end
      if (do_start) begin
        tx_shift_reg <= load_val;
        miso         <= load_val[BYTE_W-1];
        bit_cnt_reg  <= '0;
        byte_end_reg <= 1'b0;
        tx_req       <= 1'b1;
        busy         <= 1'b1;
        miso_oe      <= 1'b1;
      end else if (do_abort) begin
        busy         <= 1'b0;
        miso_oe      <= 1'b0;
        miso         <= MISO_IDLE;
        bit_cnt_reg  <= '0;
        byte_end_reg <= 1'b0;
      end else if (do_rise) begin
        rx_shift_reg <= {rx_shift_reg[BYTE_W-2:0], mosi_s};
        bit_cnt_reg  <= bit_cnt_reg + 1'b1;
        if (bit_cnt_reg == '1) begin
          rx_byte      <= {rx_shift_reg[BYTE_W-2:0], mosi_s};
          rx_valid     <= 1'b1;
          byte_end_reg <= 1'b1;
        end
      end else if (do_fall) begin
        // The falling edge after the last bit preloads the next byte's MSB.
        if (byte_end_reg) begin
          tx_shift_reg <= load_val;
          miso         <= load_val[BYTE_W-1];
          tx_req       <= 1'b1;
          byte_end_reg <= 1'b0;
        end else begin
          tx_shift_reg <= {tx_shift_reg[BYTE_W-2:0], 1'b1};
          miso         <= tx_shift_reg[BYTE_W-2];
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a mode-0 master model drives whole bytes while a
// monitor checks every rx_valid against a queue of bytes the master sent.
module tb_spi_slave;
  localparam int SS   = 2;
  localparam int HALF = 50;

  logic       sclk = 1'b0;
  logic       nrst = 1'b0;
  logic       cs_n = 1'b1;
  logic       sck  = 1'b0;
  logic       mosi = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       tx_load = 1'b0;
  logic       miso, miso_oe, tx_req, rx_valid, busy;
  logic [7:0] rx_byte;

  int n_checks = 0;
  int n_fail = 0;
  int tx_req_cnt = 0;
  int rx_cnt = 0;
  logic [7:0] rx_q[$];

  spi_slave #(.MISO_IDLE(1'b1), .SYNC_STAGES(SS)) dut (
    .sclk(sclk), .nrst(nrst), .cs_n(cs_n), .sck(sck), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_byte(tx_byte), .tx_load(tx_load),
    .tx_req(tx_req), .rx_byte(rx_byte), .rx_valid(rx_valid), .busy(busy)
  );

  always #5 sclk = ~sclk;

  always @(negedge sclk) begin
    if (nrst) begin
      if (tx_req) tx_req_cnt++;
      if (rx_valid) begin
        logic [7:0] exp_b;
        rx_cnt++;
        n_checks++;
        if (rx_q.size() == 0) begin
          n_fail++;
          $display("FAIL rx_unexpected: got rx_byte=%h, required no rx_valid", rx_byte);
        end else begin
          exp_b = rx_q.pop_front();
          if (rx_byte !== exp_b) begin
            n_fail++;
            $display("FAIL rx_byte: got %h, required %h", rx_byte, exp_b);
          end else begin
            $display("rx byte %h ok", rx_byte);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sclk);
    #1;
  endtask

  task automatic load_tx(input logic [7:0] v);
    tx_byte = v;
    tx_load = 1'b1;
    tick(1);
    tx_load = 1'b0;
  endtask

  task automatic cs_fall_wait();
    int t0;
    t0 = tx_req_cnt;
    cs_n = 1'b0;
    for (int i = 0; i < 20 && tx_req_cnt == t0; i++) tick(1);
    n_checks++;
    if (tx_req_cnt != t0 + 1) begin
      n_fail++;
      $display("FAIL tx_req_at_cs_fall: got %0d pulses, required 1", tx_req_cnt - t0);
    end
  endtask

  // On the last byte, sck falls and cs_n rises together; cs_n wins.
  task automatic master_byte(input logic [7:0] mo, input bit last, output logic [7:0] mi);
    rx_q.push_back(mo);
    mi = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      mosi = mo[i];
      tick(HALF);
      sck = 1'b1;
      mi[i] = miso;
      tick(HALF);
      sck = 1'b0;
      if (i == 0 && last) cs_n = 1'b1;
    end
    if (last) tick(20);
    $display("master sent %h received %h", mo, mi);
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    tick(4);
    n_checks += 6;
    if (miso !== 1'b1) begin n_fail++; $display("FAIL reset_miso: got %b, required 1", miso); end
    if (miso_oe !== 1'b0) begin n_fail++; $display("FAIL reset_miso_oe: got %b, required 0", miso_oe); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
    if (tx_req !== 1'b0) begin n_fail++; $display("FAIL reset_tx_req: got %b, required 0", tx_req); end
    if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b, required 0", rx_valid); end
    if (rx_byte !== 8'h00) begin n_fail++; $display("FAIL reset_rx_byte: got %h, required 00", rx_byte); end
    nrst = 1'b1;
    tick(5);
  endtask

  task automatic test_single();
    logic [7:0] got;
    int tr0, rc0;
    load_tx(8'hA5);
    tr0 = tx_req_cnt;
    rc0 = rx_cnt;
    cs_fall_wait();
    n_checks += 2;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b, required 1", busy); end
    if (miso_oe !== 1'b1) begin n_fail++; $display("FAIL single_miso_oe: got %b, required 1", miso_oe); end
    master_byte(8'h3C, 1'b1, got);
    n_checks += 5;
    if (got !== 8'hA5) begin n_fail++; $display("FAIL single_miso: got %h, required a5", got); end
    if (tx_req_cnt - tr0 != 1) begin n_fail++; $display("FAIL single_tx_req: got %0d, required 1", tx_req_cnt - tr0); end
    if (rx_cnt - rc0 != 1) begin n_fail++; $display("FAIL single_rx_cnt: got %0d, required 1", rx_cnt - rc0); end
    if (rx_byte !== 8'h3C) begin n_fail++; $display("FAIL single_rx_hold: got %h, required 3c", rx_byte); end
    if (miso_oe !== 1'b0) begin n_fail++; $display("FAIL single_oe_off: got %b, required 0", miso_oe); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] g0, g1;
    int tr0, rc0;
    load_tx(8'h12);
    tr0 = tx_req_cnt;
    rc0 = rx_cnt;
    cs_fall_wait();
    load_tx(8'h34);
    master_byte(8'h81, 1'b0, g0);
    master_byte(8'h7E, 1'b1, g1);
    n_checks += 4;
    if (g0 !== 8'h12) begin n_fail++; $display("FAIL b2b_miso0: got %h, required 12", g0); end
    if (g1 !== 8'h34) begin n_fail++; $display("FAIL b2b_miso1: got %h, required 34", g1); end
    if (tx_req_cnt - tr0 != 2) begin n_fail++; $display("FAIL b2b_tx_req: got %0d, required 2", tx_req_cnt - tr0); end
    if (rx_cnt - rc0 != 2) begin n_fail++; $display("FAIL b2b_rx_cnt: got %0d, required 2", rx_cnt - rc0); end
  endtask

  task automatic test_no_reload();
    logic [7:0] g0, g1;
    load_tx(8'h5A);
    cs_fall_wait();
    master_byte(8'h11, 1'b0, g0);
    master_byte(8'h22, 1'b1, g1);
    n_checks += 2;
    if (g0 !== 8'h5A) begin n_fail++; $display("FAIL noreload_miso0: got %h, required 5a", g0); end
    if (g1 !== 8'h5A) begin n_fail++; $display("FAIL noreload_miso1: got %h, required 5a", g1); end
  endtask

  task automatic test_abort();
    logic [7:0] got, prev;
    int rc0;
    prev = rx_byte;
    rc0 = rx_cnt;
    cs_fall_wait();
    for (int i = 0; i < 5; i++) begin
      mosi = i[0];
      tick(HALF);
      sck = 1'b1;
      tick(HALF);
      sck = 1'b0;
    end
    tick(HALF);
    cs_n = 1'b1;
    tick(SS + 2);
    n_checks += 5;
    if (miso !== 1'b1) begin n_fail++; $display("FAIL abort_miso: got %b, required 1", miso); end
    if (miso_oe !== 1'b0) begin n_fail++; $display("FAIL abort_miso_oe: got %b, required 0", miso_oe); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b, required 0", busy); end
    if (rx_byte !== prev) begin n_fail++; $display("FAIL abort_rx_byte: got %h, required %h", rx_byte, prev); end
    if (rx_cnt != rc0) begin n_fail++; $display("FAIL abort_rx_valid: got %0d pulses, required 0", rx_cnt - rc0); end
    tick(20);
    cs_fall_wait();
    master_byte(8'hC3, 1'b1, got);
    n_checks++;
    if (got !== 8'h5A) begin n_fail++; $display("FAIL abort_next_miso: got %h, required 5a", got); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] got;
    load_tx(8'h42);
    cs_fall_wait();
    for (int i = 0; i < 3; i++) begin
      mosi = 1'b1;
      tick(HALF);
      sck = 1'b1;
      tick(HALF);
      sck = 1'b0;
    end
    tick(10);
    nrst = 1'b0;
    tick(1);
    n_checks += 6;
    if (miso !== 1'b1) begin n_fail++; $display("FAIL rstmid_miso: got %b, required 1", miso); end
    if (miso_oe !== 1'b0) begin n_fail++; $display("FAIL rstmid_miso_oe: got %b, required 0", miso_oe); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b, required 0", busy); end
    if (rx_byte !== 8'h00) begin n_fail++; $display("FAIL rstmid_rx_byte: got %h, required 00", rx_byte); end
    if (tx_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_tx_req: got %b, required 0", tx_req); end
    if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_rx_valid: got %b, required 0", rx_valid); end
    cs_n = 1'b1;
    nrst = 1'b1;
    tick(20);
    cs_fall_wait();
    master_byte(8'h0F, 1'b1, got);
    n_checks++;
    if (got !== 8'hFF) begin n_fail++; $display("FAIL rstmid_next_miso: got %h, required ff", got); end
  endtask

  task automatic test_bypass();
    logic [7:0] got;
    load_tx(8'h11);
    tick(5);
    cs_n = 1'b0;
    tick(SS);
    tx_byte = 8'h99;
    tx_load = 1'b1;
    tick(1);
    tx_load = 1'b0;
    n_checks++;
    if (tx_req !== 1'b1) begin n_fail++; $display("FAIL bypass_tx_req: got %b, required 1", tx_req); end
    master_byte(8'h55, 1'b1, got);
    n_checks++;
    if (got !== 8'h99) begin n_fail++; $display("FAIL bypass_miso: got %h, required 99", got); end
    cs_fall_wait();
    master_byte(8'hAA, 1'b1, got);
    n_checks++;
    if (got !== 8'h99) begin n_fail++; $display("FAIL bypass_buf: got %h, required 99", got); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_no_reload();
    test_abort();
    test_reset_mid();
    test_bypass();
    tick(10);
    n_checks++;
    if (rx_q.size() != 0) begin
      n_fail++;
      $display("FAIL rx_outstanding: got %0d bytes never received, required 0", rx_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter MISO_IDLE, default 1'b1: level driven on miso while deselected.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth on cs_n, sck and mosi; minimum 2.
REQ-003 sclk  input  1  system clock; the block has exactly one clock domain.
REQ-004 nrst  input  1  reset; synchronous, active-low.
REQ-005 cs_n  input  1  chip select from the external master, active-low, asynchronous to sclk.
REQ-006 sck  input  1  SPI clock from the master (mode 0: idle low), asynchronous.
REQ-007 mosi  input  1  serial data from the master, MSB first, asynchronous.
REQ-008 miso  output  1  serial data to the master, MSB first.
REQ-009 miso_oe  output  1  tri-state enable for the external pad; high while selected.
REQ-010 tx_byte  input  8  next byte to transmit; captured when tx_load is high.
REQ-011 tx_load  input  1  one-cycle strobe that writes tx_byte into the transmit buffer.
REQ-012 tx_req  output  1  one-cycle pulse when the transmit buffer is consumed into the shifter.
REQ-013 rx_byte  output  8  last complete received byte, held until the next one completes.
REQ-014 rx_valid  output  1  one-cycle pulse when rx_byte is updated.
REQ-015 busy  output  1  high while synchronized cs_n is low.

Function
REQ-016 cs_n, sck and mosi each pass through a SYNC_STAGES-flop synchronizer, plus one history flop on cs_n and sck for edge detection; all logic uses the synchronized versions.
REQ-017 The FSM has two states: IDLE (cs_n high) and SHIFT (cs_n low).
REQ-018 IDLE -> SHIFT on a cs_n falling edge: tx_shift <= tx_buf, miso <= tx_buf[7], bit_cnt <= 0, tx_req pulses, busy <= 1, miso_oe <= 1.
REQ-019 On each sck rising edge in SHIFT: rx_shift <= {rx_shift[6:0], mosi_s}, bit_cnt <= bit_cnt + 1 (3-bit, wraps 7 -> 0).
REQ-020 On the rising edge with bit_cnt == 7: rx_byte <= {rx_shift[6:0], mosi_s}, rx_valid pulses for 1 cycle, byte_end flag set.
REQ-021 On each sck falling edge in SHIFT with byte_end set: tx_shift <= tx_buf, miso <= tx_buf[7], tx_req pulses, byte_end cleared.
REQ-022 Otherwise, on each falling edge: tx_shift shifts left one bit and miso <= the next bit (bit 6 .. bit 0 in order).
REQ-023 Latency: the registered response (rx_valid, miso update) occurs on the (SYNC_STAGES+1)th sclk rising edge after the edge that first samples the sck transition.
REQ-024 The master's sck high and low phases are each at least 2*(SYNC_STAGES+1) sclk cycles, and cs_n falls at least that long before the first sck rise; behaviour outside these limits is undefined.
REQ-025 tx_buf keeps its value after being consumed; without a new tx_load the same byte is sent again.
REQ-026 If tx_load coincides with a shifter load, tx_byte bypasses tx_buf into the shifter, and is also written into tx_buf.
REQ-027 A cs_n rising edge in any bit position returns the FSM to IDLE: a partial byte is discarded with no rx_valid, and busy <= 0, miso_oe <= 0, miso <= MISO_IDLE, bit_cnt <= 0, byte_end <= 0.
REQ-028 sck edges are ignored while in IDLE.
REQ-029 If cs_n rising and an sck edge are detected in the same cycle, cs_n takes priority and the sck edge is ignored.

Reset
REQ-030 While nrst is low at a sclk rising edge, all registers load their reset values: miso = MISO_IDLE, miso_oe = 0, busy = 0, tx_req = 0, rx_valid = 0, rx_byte = 8'h00, tx_buf = 8'hFF, tx_shift = 8'hFF, rx_shift = 8'h00, bit_cnt = 0, byte_end = 0, FSM = IDLE.
REQ-031 Synchronizer reset values are cs_n 1, sck 0, mosi 0, so no false edge is detected on release.
REQ-032 Reset asserted mid-transfer aborts the transfer exactly as in REQ-027, plus the buffer reset values of REQ-030.

Structure
REQ-033 The shared package spi_pkg holds the FSM state encoding, the byte width (8), the bit-counter width (3) and the default MISO_IDLE value.
REQ-034 The synchronizer is the sub-module spi_sync (parameter SYNC_STAGES, synchronous active-low reset, configurable reset value), instantiated three times.

Verification
REQ-035 Load 8'hA5, then the master sends 8'h3C at 100 sclk per sck period -> rx_byte = 8'h3C with one rx_valid pulse; master receives 8'hA5; exactly one tx_req at cs_n fall.
REQ-036 Two back-to-back bytes: load 8'h12, master sends 8'h81; on the tx_req pulse load 8'h34, master sends 8'h7E -> master receives 12, 34; rx_valid pulses twice with 81, 7E; tx_req pulses twice.
REQ-037 No reload after the first byte (8'h5A) over a two-byte transfer -> master receives 5A, 5A.
REQ-038 cs_n raised after 5 sck pulses -> no rx_valid, rx_byte unchanged, miso = 1, miso_oe = 0 within SYNC_STAGES+2 cycles; the next full transfer of 8'hC3 is received correctly.
REQ-039 nrst pulsed low mid-byte -> all outputs at their reset values on the following edge; tx_buf = FF, so the next transfer returns 8'hFF.
REQ-040 tx_load with 8'h99 in the same cycle as the cs_n-fall shifter load -> master receives 8'h99 (bypass).
